// File: rtl/riscv_pkg.sv
// Shared constants and types for the writeback / register-file slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_t;

endpackage

// File: rtl/wb_clear_seq.sv
// Post-reset clear sequencer: walks x1..x(NREGS-1) writing zero, then flags the file ready.
// Latency: ready rises on the edge that clears the last register (NREGS-1 edges after reset release).
// Backpressure: none; consumers stall on o_ready==0.
module wb_clear_seq
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_idx,
    output logic          o_ready
);

    clr_state_t    r_state;
    logic [AW-1:0] r_idx;
    logic          r_ready;

    // Sweep the clear index once per cycle; x0 is never stored so the walk starts at 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
            r_idx   <= AW'(1);
            r_ready <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            if (r_idx == AW'(NREGS - 1)) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_clr_we  = (r_state == ST_CLEAR);
    assign o_clr_idx = r_idx;
    assign o_ready   = r_ready;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register-file commit, write-first bypassed decode reads.
// Latency: commit visible on RD1D/RD2D same cycle via bypass, from the array the next cycle.
// Backpressure: none; ReadyD low during the post-reset clear sweep tells the hazard unit to stall.
module wb_regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [AW-1:0]   RdW,
    input  logic [AW-1:0]   A1D,
    input  logic [AW-1:0]   A2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic            ReadyD,
    output logic [31:0]     WbCountW
);

    logic            w_clr_we;
    logic [AW-1:0]   w_clr_idx;
    logic            w_ready;
    logic            w_commit;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;

    // No reset on the array so it can map onto RAM; the clear sweep zeroes it instead.
    logic [XLEN-1:0] r_regs [NREGS];
    logic [31:0]     r_wb_count;

    wb_clear_seq u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx),
        .o_ready   (w_ready)
    );

    assign ReadyD = w_ready;

    // Writeback value select; the reserved encoding falls back to the ALU result.
    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            RESULT_MEM: ResultW = ReadDataW;
            RESULT_PC4: ResultW = PCPlus4W;
            default:    ResultW = ALUResultW;
        endcase
    end

    // Architectural commits only once the clear sweep is done, and never to x0.
    assign w_commit = w_ready && RegWriteW && (RdW != '0);

    // Single write port: the clear sweep owns it until ready, then commits take over.
    always_comb begin
        w_we    = w_clr_we || w_commit;
        w_waddr = w_clr_we ? w_clr_idx : RdW;
        w_wdata = w_clr_we ? '0 : ResultW;
    end

    // Register array write.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    // Read port 1: x0 reads zero, same-cycle writeback bypasses the array, zero until ready.
    always_comb begin
        RD1D = '0;
        if (w_ready && (A1D != '0)) begin
            if (RegWriteW && (RdW == A1D)) RD1D = ResultW;
            else                           RD1D = r_regs[A1D];
        end
    end

    // Read port 2: identical policy, independent address.
    always_comb begin
        RD2D = '0;
        if (w_ready && (A2D != '0)) begin
            if (RegWriteW && (RdW == A2D)) RD2D = ResultW;
            else                           RD2D = r_regs[A2D];
        end
    end

    // Committed-write counter, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign WbCountW = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic        ReadyD;
    logic [31:0] WbCountW;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .A1D        (A1D),
        .A2D        (A2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .ReadyD     (ReadyD),
        .WbCountW   (WbCountW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_res;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        RegWriteW  = 1'b0;
        ResultSrcW = 2'b00;
        ALUResultW = 32'h0;
        ReadDataW  = 32'h0;
        PCPlus4W   = 32'h0;
        RdW        = 5'd0;
        A1D        = 5'd0;
        A2D        = 5'd0;
    endtask

    initial begin
        //          we    src    alu            rdat           pc4        rd     a1     a2     e_rd1          e_rd2          e_res          e_cnt
        vecs[0]  = '{1'b1, 2'd0, 32'h0000_1234, 32'h0,         32'h0,     5'd5,  5'd5,  5'd0,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'd1};
        vecs[1]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,     5'd0,  5'd5,  5'd5,  32'h0000_1234, 32'h0000_1234, 32'h0,         32'd1};
        vecs[2]  = '{1'b1, 2'd1, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0,     5'd7,  5'd7,  5'd5,  32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF, 32'd2};
        vecs[3]  = '{1'b1, 2'd2, 32'h0000_0099, 32'h0000_0022, 32'h104,   5'd8,  5'd8,  5'd7,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0104, 32'd3};
        vecs[4]  = '{1'b1, 2'd3, 32'h0000_0055, 32'h0000_0077, 32'h200,   5'd9,  5'd9,  5'd8,  32'h0000_0055, 32'h0000_0104, 32'h0000_0055, 32'd4};
        vecs[5]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,     5'd0,  5'd7,  5'd9,  32'hDEAD_BEEF, 32'h0000_0055, 32'h0,         32'd4};
        vecs[6]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0,         32'h0,     5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'hFFFF_FFFF, 32'd4};
        vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,     5'd0,  5'd0,  5'd8,  32'h0,         32'h0000_0104, 32'h0,         32'd4};
        vecs[8]  = '{1'b1, 2'd0, 32'h0000_A5A5, 32'h0,         32'h0,     5'd5,  5'd5,  5'd5,  32'h0000_A5A5, 32'h0000_A5A5, 32'h0000_A5A5, 32'd5};
        vecs[9]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,     5'd0,  5'd5,  5'd9,  32'h0000_A5A5, 32'h0000_0055, 32'h0,         32'd5};
        vecs[10] = '{1'b1, 2'd0, 32'h0000_1F1F, 32'h0,         32'h0,     5'd31, 5'd31, 5'd30, 32'h0000_1F1F, 32'h0,         32'h0000_1F1F, 32'd6};
        vecs[11] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0,     5'd0,  5'd31, 5'd1,  32'h0000_1F1F, 32'h0,         32'h0,         32'd6};

        // Reset for two edges, then watch the clear sweep.
        reset = 1'b0;
        idle_inputs();
        A1D = 5'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, ReadyD}, 32'd0);
        check("reset_count", WbCountW, 32'd0);
        check("reset_rd1", RD1D, 32'd0);
        reset = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            check("clear_ready", {31'd0, ReadyD}, (k == 31) ? 32'd1 : 32'd0);
            if (k == 10) check("clear_rd1_zero", RD1D, 32'd0);
        end

        // Every register reads zero after the sweep.
        @(negedge clk);
        for (int a = 1; a <= 31; a++) begin
            A1D = 5'(a);
            A2D = 5'(32 - a);
            #1;
            check("post_clear_rd1", RD1D, 32'd0);
            check("post_clear_rd2", RD2D, 32'd0);
        end

        // Table-driven RUN-mode vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            RegWriteW  = vecs[i].we;
            ResultSrcW = vecs[i].src;
            ALUResultW = vecs[i].alu;
            ReadDataW  = vecs[i].rdat;
            PCPlus4W   = vecs[i].pc4;
            RdW        = vecs[i].rd;
            A1D        = vecs[i].a1;
            A2D        = vecs[i].a2;
            #1;
            check($sformatf("vec%0d_rd1", i), RD1D, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), RD2D, vecs[i].e_rd2);
            check($sformatf("vec%0d_result", i), ResultW, vecs[i].e_res);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), WbCountW, vecs[i].e_cnt);
        end

        // Mid-RUN reset: x3 written, reset pulsed with a write pending, writes ignored during CLEAR.
        @(negedge clk);
        idle_inputs();
        RegWriteW  = 1'b1;
        ALUResultW = 32'h0000_00AA;
        RdW        = 5'd3;
        A1D        = 5'd3;
        @(posedge clk);
        #1;
        check("x3_count", WbCountW, 32'd7);
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        check("x3_array", RD1D, 32'h0000_00AA);
        @(negedge clk);
        reset      = 1'b0;
        RegWriteW  = 1'b1;
        ALUResultW = 32'h0000_00BB;
        @(posedge clk);
        #1;
        check("rerst_ready", {31'd0, ReadyD}, 32'd0);
        check("rerst_count", WbCountW, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            check("reclear_ready", {31'd0, ReadyD}, (k == 31) ? 32'd1 : 32'd0);
            if (k < 31) check("reclear_rd1", RD1D, 32'd0);
            if (k == 5) check("reclear_result", ResultW, 32'h0000_00BB);
        end
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        check("reclear_x3_zero", RD1D, 32'd0);
        check("reclear_count", WbCountW, 32'd0);

        // Counter wrap from all-ones via backdoor preload.
        @(negedge clk);
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        RegWriteW  = 1'b1;
        ALUResultW = 32'h0000_0001;
        RdW        = 5'd4;
        A1D        = 5'd4;
        #1;
        check("wrap_pre", WbCountW, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("wrap_post", WbCountW, 32'd0);
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        check("wrap_x4", RD1D, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
